spi_seq_slave: RTL

- Parametrised SPI mode-0 slave that streams a selectable generated sequence on MISO: Fibonacci, up-counter, Galois LFSR, or echo of the previous MOSI word.
- Word width is a parameter.
- The first MOSI word of a message can select the mode for subsequent messages.
- All logic runs in the system clock domain. There are no derived or gated clocks, and the generator advances on an internal enable.

---
 rtl/spi_seq_slave.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_seq_slave.sv
// SPI mode-0 slave that streams a generated word sequence (fib / count / lfsr / echo) on MISO.
// SCK, SSEL and MOSI are oversampled in the clk domain; nothing is clocked by SCK.
module spi_seq_slave #(
  parameter int                DATA_W    = 8,
  parameter logic [1:0]        MODE_INIT = 2'd0,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [1:0]        mode,
  output logic [15:0]       word_cnt
);

  localparam int            CW   = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic [1:0] M_FIB  = 2'd0;
  localparam logic [1:0] M_CNT  = 2'd1;
  localparam logic [1:0] M_LFSR = 2'd2;
  localparam logic [1:0] M_ECHO = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } gen_t;

  function automatic gen_t seed_of(input logic [1:0] m);
    gen_t s;
    s = '0;
    case (m)
      M_FIB:   s.b = DATA_W'(1);
      M_LFSR:  s.a = LFSR_SEED;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic gen_t advance(input gen_t g, input logic [1:0] m,
                                   input logic [DATA_W-1:0] w);
    gen_t              s;
    logic [DATA_W-1:0] nx;
    s  = g;
    nx = (g.a >> 1) ^ (g.a[0] ? LFSR_TAPS : '0);
    case (m)
      M_FIB:   begin s.a = g.b; s.b = g.a + g.b; end
      M_CNT:   s.a = g.a + 1'b1;
      M_LFSR:  s.a = (nx == '0) ? LFSR_SEED : nx;
      M_ECHO:  s.a = w;
      default: s = g;
    endcase
    return s;
  endfunction

  logic [2:0]        sck_s, ssel_s;
  logic [1:0]        mosi_s;
  logic              sck_rise, sck_fall, ssel_start, ssel_end, ssel_act;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_sh, rx_word, tx_sh;
  logic              rx_last, first_w, pend_vld;
  logic [1:0]        pend_mode;
  gen_t              gen;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s  <= '0;
      ssel_s <= 3'b111;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], SCK};
      ssel_s <= {ssel_s[1:0], SSEL};
      mosi_s <= {mosi_s[0], MOSI};
    end
  end

  assign sck_rise   = (sck_s[2:1] == 2'b01);
  assign sck_fall   = (sck_s[2:1] == 2'b10);
  assign ssel_start = (ssel_s[2:1] == 2'b10);
  assign ssel_end   = (ssel_s[2:1] == 2'b01);
  assign ssel_act   = ~ssel_s[1];
  assign rx_word    = {rx_sh[DATA_W-2:0], mosi_s[1]};
  assign rx_last    = sck_rise & ssel_act & (bit_cnt == LAST);

  // receive path: bit counter, shift register, word strobe and word count
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      word_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!ssel_act) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        rx_sh   <= rx_word;
      end
      if (ssel_start) begin
        word_cnt <= '0;
      end else if (rx_last) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_word;
        if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
      end
    end
  end

  // first word of a message may carry a mode command, applied at message end
  always_ff @(posedge clk) begin
    if (rst) begin
      first_w   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_mode <= '0;
      mode      <= MODE_INIT;
    end else begin
      if (ssel_start) begin
        first_w <= 1'b1;
      end else if (rx_last) begin
        first_w <= 1'b0;
        if (first_w && rx_word[DATA_W-1]) begin
          pend_vld  <= 1'b1;
          pend_mode <= rx_word[1:0];
        end
      end
      if (ssel_end && pend_vld) begin
        mode     <= pend_mode;
        pend_vld <= 1'b0;
      end
    end
  end

  // generator advances one cycle after the word strobe; a start event overrides it
  always_ff @(posedge clk) begin
    if (rst)             gen <= seed_of(MODE_INIT);
    else if (ssel_start) gen <= seed_of(mode);
    else if (rx_valid)   gen <= advance(gen, mode, rx_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh <= '0;
    end else if (ssel_start) begin
      tx_sh <= seed_of(mode).a;
    end else if (ssel_act && sck_fall) begin
      tx_sh <= (bit_cnt == '0) ? gen.a : {tx_sh[DATA_W-2:0], 1'b0};
    end
  end

  assign MISO = tx_sh[DATA_W-1];

endmodule
